microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Micro-program sequencer that drives the 5-bit address of the 32x4 microcode ROM and consumes the ROM's 4-bit microword.
- On a start request it dispatches a 2-bit opcode to a routine entry point, then steps the micro-PC through the routine.
- Issues each control microword downstream as a registered uop with a valid strobe, and terminates on END (1000) or TRAP (1111).
- Sits between the instruction front-end (start/op) and the datapath control decode (uop/uop_valid).

Parameters:
- ENTRY0, 5'd0: routine entry address for op=0
- ENTRY1, 5'd9: routine entry address for op=1
- ENTRY2, 5'd17: routine entry address for op=2
- ENTRY3, 5'd27: routine entry address for op=3
- MAX_STEPS, 16: watchdog limit, in ROM reads per routine

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  dispatch request, sampled only in IDLE or TRAP
- op  in  2  opcode selecting the entry point, sampled with start
- stall  in  1  downstream hold; freezes the sequencer while RUN
- rom_addr  out  5  address to the microcode ROM, equal to the mpc register
- rom_data  in  4  microword from the ROM, combinational from rom_addr
- uop  out  4  registered control microword to the datapath
- uop_valid  out  1  uop is valid this cycle
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse when a routine ends normally
- err  out  1  sticky error flag, set on TRAP or watchdog

Behaviour:
- Reset (asynchronous, rst_n=0), all outputs cleared:
  - state=IDLE, mpc=0, step=0
  - uop=0, uop_valid=0, busy=0, done=0, err=0
- States are IDLE, RUN and TRAP.
- IDLE:
  - start=1 loads mpc<=ENTRYn (n=op) and step<=0, and sets state<=RUN.
  - start=0 holds mpc.
  - uop_valid=0.
- RUN with stall=1: mpc, step and uop hold; uop_valid<=0; done<=0.
- RUN with stall=0, the decode of rom_data applies each cycle:
  - 1000 END: done<=1 for one cycle; uop_valid<=0; state<=IDLE; mpc holds.
  - 1111 TRAP: err<=1; uop_valid<=0; state<=TRAP; mpc holds.
  - 0000 NOP: mpc<=mpc+1; uop_valid<=0.
  - Any other code: uop<=rom_data; uop_valid<=1; mpc<=mpc+1.
  - step<=step+1 on every non-stalled read.
  - If step reaches MAX_STEPS before END, this takes priority over the decode: err<=1, state<=TRAP, uop_valid<=0.
- mpc arithmetic is 5-bit modulo 32 (31 wraps to 0). Wrap is not an error in itself.
- Latency:
  - The ROM is read one cycle after start is accepted.
  - The uop for address k appears the cycle after mpc=k is read.
  - done appears the cycle after END is read; busy falls in the same cycle.
- busy=1 exactly while state=RUN.
- start asserted in RUN is ignored, with no queueing.
- TRAP:
  - uop_valid=0, busy=0; err stays high.
  - start=1 clears err and dispatches exactly as from IDLE.
- uop keeps its last value when uop_valid=0.
- done and uop_valid are never high in the same cycle.
- rst_n asserted mid-routine aborts immediately to reset values. There is no done pulse, and err is cleared.

Test Plan:
- Reset, then start=1 with op=0 at cycle T, driven by the production ROM contents:
  - uop_valid high T+3..T+9 with uop sequence 1,4,5,7,5,3,6
  - done high only at T+10; busy high T+1..T+9
  - rom_addr sequence 0..8
- op=2 (entry 17): uop sequence 4,5,5,5,5,3,6,6,6; done after the read at address 26; err=0, since 10 steps is under MAX_STEPS.
- op=3 (entry 27): one uop=0010, then TRAP at address 28, with err=1 and busy=0.
  - A following start with op=1 clears err.
  - It then yields 4,5,5,5,3,6,6 and done.
- op=0 with stall=1 held for 3 cycles at mpc=3:
  - rom_addr holds at 3 and uop_valid=0 during the stall.
  - The uop sequence is unchanged, and done is delayed by exactly 3 cycles.
- The bench drives rom_data=0101 constantly from ENTRY0:
  - 16 uops are issued, then the watchdog trips with err=1 and state TRAP.
  - mpc wraps correctly if ENTRY is set to 30.
- Assert rst_n=0 asynchronously mid-routine, at mpc=12 during op=1:
  - All outputs go to 0 within the same cycle, with no done pulse.
  - A start=1 in the same cycle as busy=1 is ignored.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: dispatches a 2-bit opcode to a routine entry, walks the
// micro-PC through the 32x4 ROM and issues registered control uops downstream.
module microcode_sequencer #(
  parameter logic [4:0] ENTRY0    = 5'd0,
  parameter logic [4:0] ENTRY1    = 5'd9,
  parameter logic [4:0] ENTRY2    = 5'd17,
  parameter logic [4:0] ENTRY3    = 5'd27,
  parameter int         MAX_STEPS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       stall,
  output logic [4:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic [3:0] uop,
  output logic       uop_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int SW = $clog2(MAX_STEPS + 1);

  localparam logic [3:0] CODE_NOP  = 4'b0000;
  localparam logic [3:0] CODE_END  = 4'b1000;
  localparam logic [3:0] CODE_TRAP = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, TRAP} state_t;

  state_t        state;
  logic [4:0]    mpc;
  logic [SW-1:0] step;
  logic [4:0]    entry;

  assign rom_addr = mpc;

  always_comb begin
    entry = ENTRY0;
    case (op)
      2'd0: entry = ENTRY0;
      2'd1: entry = ENTRY1;
      2'd2: entry = ENTRY2;
      2'd3: entry = ENTRY3;
      default: entry = ENTRY0;
    endcase
  end

  // uop_valid and done are single-cycle strobes; busy mirrors the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mpc       <= '0;
      step      <= '0;
      uop       <= '0;
      uop_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      uop_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE, TRAP: begin
          if (start) begin
            mpc   <= entry;
            step  <= '0;
            state <= RUN;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            step <= step + 1'b1;
            // a runaway routine traps before its current word is decoded
            if (step >= SW'(MAX_STEPS)) begin
              err   <= 1'b1;
              state <= TRAP;
              busy  <= 1'b0;
            end else begin
              case (rom_data)
                CODE_END: begin
                  done  <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
                end
                CODE_TRAP: begin
                  err   <= 1'b1;
                  state <= TRAP;
                  busy  <= 1'b0;
                end
                CODE_NOP: begin
                  mpc <= mpc + 5'd1;
                end
                default: begin
                  uop       <= rom_data;
                  uop_valid <= 1'b1;
                  mpc       <= mpc + 5'd1;
                end
              endcase
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: models the production ROM and checks
// routine uop streams, stall, trap, watchdog, wrap and asynchronous reset.
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic       stall;
  logic [4:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] uop;
  logic       uop_valid;
  logic       busy;
  logic       done;
  logic       err;

  logic [3:0] rom [32];
  logic       romConst;
  int         compared   = 0;
  int         mismatched = 0;
  int         cyc        = 0;
  int         doneAt;
  int         errAt;
  logic [3:0] gotUops [$];
  logic [3:0] seq0 [$];
  logic [3:0] seq1 [$];
  logic [3:0] seq2 [$];
  logic [3:0] seqWd [$];

  microcode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .stall(stall),
    .rom_addr(rom_addr), .rom_data(rom_data), .uop(uop), .uop_valid(uop_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign rom_data = romConst ? 4'b0101 : rom[rom_addr];

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] opc);
    start = 1'b1;
    op    = opc;
    tick();
    start = 1'b0;
  endtask

  // Samples from the cycle after the start edge until done, err or budget
  task automatic captureRun(input int stallAt, input int stallLen, input logic [4:0] stallAddr, input int budget);
    logic overlap;
    overlap = 1'b0;
    gotUops.delete();
    doneAt = -1;
    errAt  = -1;
    for (int k = 1; k <= budget; k++) begin
      if (uop_valid) gotUops.push_back(uop);
      if (done && uop_valid) overlap = 1'b1;
      if (k > stallAt && k <= stallAt + stallLen) begin
        checkOutput("stallAddr", rom_addr, stallAddr);
        checkOutput("stallValid", uop_valid, 1'b0);
      end
      if (done) begin doneAt = k; break; end
      if (err)  begin errAt  = k; break; end
      stall = (k >= stallAt && k < stallAt + stallLen);
      tick();
    end
    stall = 1'b0;
    checkOutput("exclusive", overlap, 1'b0);
    checkOutput("timeout", (doneAt < 0 && errAt < 0), 1'b0);
  endtask

  task automatic compareUops(input string tag, input logic [3:0] expd [$]);
    checkOutput({tag, "Count"}, gotUops.size(), expd.size());
    for (int i = 0; i < expd.size() && i < gotUops.size(); i++)
      checkOutput(tag, gotUops[i], expd[i]);
  endtask

  initial begin
    rom = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h7, 4'h5, 4'h3, 4'h6, 4'h8,
            4'h4, 4'h5, 4'h5, 4'h5, 4'h3, 4'h6, 4'h6, 4'h8,
            4'h4, 4'h5, 4'h5, 4'h5, 4'h5, 4'h3, 4'h6, 4'h6, 4'h6, 4'h8,
            4'h2, 4'hF, 4'h0, 4'h0, 4'h0};
    seq0 = '{4'h1, 4'h4, 4'h5, 4'h7, 4'h5, 4'h3, 4'h6};
    seq1 = '{4'h4, 4'h5, 4'h5, 4'h5, 4'h3, 4'h6, 4'h6};
    seq2 = '{4'h4, 4'h5, 4'h5, 4'h5, 4'h5, 4'h3, 4'h6, 4'h6, 4'h6};
    for (int i = 0; i < 16; i++) seqWd.push_back(4'h5);
    romConst = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    stall = 1'b0;
    tick();
    tick();
    checkOutput("rstAddr", rom_addr, 5'd0);
    checkOutput("rstUop", uop, 4'h0);
    checkOutput("rstValid", uop_valid, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    checkOutput("rstErr", err, 1'b0);
    rst_n = 1'b1;
    tick();

    // op0 cycle by cycle: NOP at 0, uops at T+3..T+9, done at T+10
    applyStimulus(2'd0);
    for (int k = 1; k <= 11; k++) begin
      checkOutput("op0Busy", busy, (k <= 9));
      checkOutput("op0Addr", rom_addr, (k <= 9) ? k - 1 : 8);
      checkOutput("op0Valid", uop_valid, (k >= 3 && k <= 9));
      if (k >= 3 && k <= 9) checkOutput("op0Uop", uop, seq0[k-3]);
      checkOutput("op0Done", done, (k == 10));
      tick();
    end

    // op0 with a three-cycle stall while mpc=3
    applyStimulus(2'd0);
    captureRun(4, 3, 5'd3, 40);
    compareUops("stallUops", seq0);
    checkOutput("stallDoneAt", doneAt, 13);

    // op2: ten reads, END at address 26
    applyStimulus(2'd2);
    captureRun(0, 0, 5'd0, 40);
    compareUops("op2Uops", seq2);
    checkOutput("op2DoneAt", doneAt, 11);
    checkOutput("op2DoneAddr", rom_addr, 5'd26);
    checkOutput("op2Err", err, 1'b0);

    // op3: one uop then TRAP at 28
    applyStimulus(2'd3);
    checkOutput("op3Addr27", rom_addr, 5'd27);
    tick();
    checkOutput("op3Addr28", rom_addr, 5'd28);
    checkOutput("op3Valid", uop_valid, 1'b1);
    checkOutput("op3Uop", uop, 4'h2);
    tick();
    checkOutput("trapErr", err, 1'b1);
    checkOutput("trapBusy", busy, 1'b0);
    checkOutput("trapValid", uop_valid, 1'b0);
    checkOutput("trapUopHold", uop, 4'h2);
    checkOutput("trapAddr", rom_addr, 5'd28);
    tick();
    checkOutput("trapSticky", err, 1'b1);

    // op1 from TRAP clears err and runs to done
    applyStimulus(2'd1);
    checkOutput("op1ErrClr", err, 1'b0);
    checkOutput("op1Busy", busy, 1'b1);
    checkOutput("op1Addr", rom_addr, 5'd9);
    captureRun(0, 0, 5'd0, 40);
    compareUops("op1Uops", seq1);
    checkOutput("op1DoneAt", doneAt, 9);

    // watchdog: constant 0101 from ENTRY0
    romConst = 1'b1;
    applyStimulus(2'd0);
    captureRun(0, 0, 5'd0, 40);
    compareUops("wdUops", seqWd);
    checkOutput("wdErrAt", errAt, 18);
    checkOutput("wdErr", err, 1'b1);
    checkOutput("wdBusy", busy, 1'b0);
    checkOutput("wdAddr", rom_addr, 5'd16);

    // mpc wrap from entry 27 under constant microwords
    applyStimulus(2'd3);
    checkOutput("wrapErrClr", err, 1'b0);
    checkOutput("wrapStart", rom_addr, 5'd27);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("wrap31", rom_addr, 5'd31);
    tick();
    checkOutput("wrap0", rom_addr, 5'd0);
    checkOutput("wrapBusy", busy, 1'b1);
    captureRun(0, 0, 5'd0, 40);
    checkOutput("wrapErr", err, 1'b1);
    checkOutput("wrapFinalAddr", rom_addr, 5'd11);

    // op1 with an ignored start in RUN, then async reset at mpc=12
    romConst = 1'b0;
    applyStimulus(2'd1);
    checkOutput("midAddr9", rom_addr, 5'd9);
    tick();
    tick();
    start = 1'b1;
    op    = 2'd2;
    tick();
    start = 1'b0;
    checkOutput("ignoreStart", rom_addr, 5'd12);
    checkOutput("midBusy", busy, 1'b1);
    checkOutput("midUop", uop, 4'h5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncAddr", rom_addr, 5'd0);
    checkOutput("asyncUop", uop, 4'h0);
    checkOutput("asyncValid", uop_valid, 1'b0);
    checkOutput("asyncBusy", busy, 1'b0);
    checkOutput("asyncErr", err, 1'b0);
    tick();
    checkOutput("asyncNoDone", done, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("postRstDone", done, 1'b0);
    checkOutput("postRstBusy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
